// File: rtl/display_scheduler_pkg.sv
// Shared encodings for the alarm-clock display path: source/state codes and digit masks.
package display_scheduler_pkg;

   localparam logic [1:0] SRC_TIME  = 2'd0;
   localparam logic [1:0] SRC_KBD   = 2'd1;
   localparam logic [1:0] SRC_ALARM = 2'd2;
   localparam logic [1:0] SRC_RING  = 2'd3;

   localparam logic [3:0] MASK_ALL  = 4'b1111;
   localparam logic [3:0] MASK_NONE = 4'b0000;

   localparam int unsigned WORD_W = 16;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/display_scheduler_sec_timer.sv
// Saturating one-second counter with synchronous clear and a compare against a runtime limit.
module display_scheduler_sec_timer #(
   parameter int unsigned CW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear_i,
   input  logic          tick_i,
   input  logic [CW-1:0] limit_i,
   output logic          reached_c_o
);

   logic [CW-1:0] count_q, count_d;

   // Clear wins over a coincident tick; the count holds at all-ones rather than wrapping.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (tick_i && (count_q != {CW{1'b1}})) begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign reached_c_o = (count_q >= limit_i);

endmodule

// File: rtl/display_scheduler.sv
// Chooses what the seven-segment display shows (time, keyboard, alarm, ringing) with
// priority, alarm minimum hold, keyboard inactivity timeout and one-second blink cadence.
module display_scheduler
   import display_scheduler_pkg::*;
#(
   parameter int unsigned KBD_TIMEOUT_S = 10,
   parameter int unsigned ALARM_HOLD_S  = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        one_second,
   input  logic        show_keyboard,
   input  logic        key_strobe,
   input  logic [15:0] key_buffer,
   input  logic        show_alarm,
   input  logic [15:0] alarm_time,
   input  logic [15:0] current_time,
   input  logic        sound_alarm,
   output logic [15:0] word_out,
   output logic [3:0]  display_mask_out,
   output logic        dp_out,
   output logic [1:0]  src_out,
   output logic        kbd_timeout
);

   localparam int unsigned CW = $clog2(max_u(KBD_TIMEOUT_S, ALARM_HOLD_S) + 1);

   logic [1:0]        state_q, state_d;
   logic              colon_q, colon_d;
   logic              blink_q, blink_d;
   logic              kbd_expired_q, kbd_expired_d;
   logic              show_alarm_q;
   logic [WORD_W-1:0] word_q, word_d;
   logic [3:0]        mask_q, mask_d;
   logic              dp_q, dp_d;
   logic              kbd_timeout_q, kbd_timeout_d;

   logic              alarm_rise_c;
   logic              timeout_c;
   logic              timer_clear_c;
   logic              reached_c;
   logic [CW-1:0]     limit_c;

   assign alarm_rise_c = show_alarm && !show_alarm_q;
   assign limit_c      = (state_q == SRC_KBD) ? CW'(KBD_TIMEOUT_S - 1) : CW'(ALARM_HOLD_S);
   assign timeout_c    = (state_q == SRC_KBD) && one_second && !key_strobe && reached_c;

   display_scheduler_sec_timer #(.CW(CW)) u_sec_timer (
      .clk         (clk),
      .reset       (reset),
      .clear_i     (timer_clear_c),
      .tick_i      (one_second),
      .limit_i     (limit_c),
      .reached_c_o (reached_c)
   );

   // Next state, flags and registered output values, all derived from the next state.
   always_comb begin
      state_d       = SRC_TIME;
      colon_d       = colon_q ^ one_second;
      blink_d       = blink_q ^ one_second;
      kbd_expired_d = show_keyboard && (kbd_expired_q || timeout_c);
      kbd_timeout_d = timeout_c;
      word_d        = current_time;
      mask_d        = MASK_ALL;
      dp_d          = 1'b0;

      if (sound_alarm) begin
         state_d = SRC_RING;
      end else if (show_keyboard && !kbd_expired_q && !timeout_c) begin
         state_d = SRC_KBD;
      end else if (alarm_rise_c) begin
         state_d = SRC_ALARM;
      end else if ((state_q == SRC_ALARM) && !(reached_c && !show_alarm)) begin
         state_d = SRC_ALARM;
      end

      // A new rising edge inside ALARM restarts the hold just like a fresh entry.
      timer_clear_c = (state_d != state_q)
                    || ((state_q == SRC_KBD) && key_strobe)
                    || ((state_q == SRC_ALARM) && alarm_rise_c);

      case (state_d)
         SRC_RING: begin
            mask_d = blink_d ? MASK_NONE : MASK_ALL;
            dp_d   = 1'b1;
         end
         SRC_KBD: begin
            word_d = key_buffer;
         end
         SRC_ALARM: begin
            word_d = alarm_time;
            dp_d   = 1'b1;
         end
         default: begin
            dp_d = colon_d;
         end
      endcase
   end

   // Edge detector resets high so a request held through reset needs a fresh rising edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= SRC_TIME;
         colon_q       <= 1'b0;
         blink_q       <= 1'b0;
         kbd_expired_q <= 1'b0;
         show_alarm_q  <= 1'b1;
         word_q        <= '0;
         mask_q        <= MASK_ALL;
         dp_q          <= 1'b0;
         kbd_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         colon_q       <= colon_d;
         blink_q       <= blink_d;
         kbd_expired_q <= kbd_expired_d;
         show_alarm_q  <= show_alarm;
         word_q        <= word_d;
         mask_q        <= mask_d;
         dp_q          <= dp_d;
         kbd_timeout_q <= kbd_timeout_d;
      end
   end

   assign word_out         = word_q;
   assign display_mask_out = mask_q;
   assign dp_out           = dp_q;
   assign src_out          = state_q;
   assign kbd_timeout      = kbd_timeout_q;

endmodule
